// File: rtl/vedic_mul_pkg.sv
// Shared constants and state encoding for the sequential vedic multiplier.
package vedic_mul_pkg;

    localparam int OP_W     = 32;               // operand width in bits
    localparam int CHUNK    = 8;                // slice width of the shared multiplier
    localparam int NCH      = OP_W / CHUNK;     // slices per operand
    localparam int SEQ_LAST = NCH * NCH - 1;    // last partial-product step index
    localparam int ACC_W    = 2 * OP_W;         // full product width
    localparam int CNT_W    = $clog2(NCH * NCH);
    localparam int IDX_W    = $clog2(NCH);      // NCH must be a power of two for the cnt split

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        MUL  = 2'd1,
        DONE = 2'd2
    } state_t;

endpackage

// File: rtl/vedic_multiplier_8x8.sv
// Combinational 8x8 unsigned multiplier built from the Urdhva-Tiryagbhyam
// (vertical and crosswise) decomposition: 2x2 cells -> 4x4 -> 8x8.
module vedic_multiplier_8x8 (
    input  logic [7:0]  a,
    input  logic [7:0]  b,
    output logic [15:0] p
);

    // 2x2 cell: vertical products on the outer bits, crosswise sum in the middle.
    function automatic logic [3:0] vm2(input logic [1:0] x, input logic [1:0] y);
        logic s1;
        logic c1;
        logic [1:0] hi;
        s1 = (x[1] & y[0]) ^ (x[0] & y[1]);
        c1 = (x[1] & y[0]) & (x[0] & y[1]);
        hi = {1'b0, x[1] & y[1]} + {1'b0, c1};
        return {hi, s1, x[0] & y[0]};
    endfunction

    // 4x4 block from four 2x2 cells; crosswise terms land at weight 2^2.
    function automatic logic [7:0] vm4(input logic [3:0] x, input logic [3:0] y);
        logic [3:0] q0, q1, q2, q3;
        q0 = vm2(x[1:0], y[1:0]);
        q1 = vm2(x[3:2], y[1:0]);
        q2 = vm2(x[1:0], y[3:2]);
        q3 = vm2(x[3:2], y[3:2]);
        return {4'b0, q0} + {2'b0, q1, 2'b0} + {2'b0, q2, 2'b0} + {q3, 4'b0};
    endfunction

    // 8x8 product from four 4x4 blocks; crosswise terms land at weight 2^4.
    always_comb begin : mul_tree
        logic [7:0] r0, r1, r2, r3;
        r0 = vm4(a[3:0], b[3:0]);
        r1 = vm4(a[7:4], b[3:0]);
        r2 = vm4(a[3:0], b[7:4]);
        r3 = vm4(a[7:4], b[7:4]);
        p  = {8'b0, r0} + {4'b0, r1, 4'b0} + {4'b0, r2, 4'b0} + {r3, 8'b0};
    end

endmodule

// File: rtl/vedic_mul32_seq_ctrl.sv
// Sequential OP_W x OP_W unsigned multiplier: one shared 8x8 vedic multiplier
// is stepped over all NCH*NCH byte pairs, accumulating shifted partial products.
module vedic_mul32_seq_ctrl
    import vedic_mul_pkg::*;
(
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [OP_W-1:0]   a,
    input  logic [OP_W-1:0]   b,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [ACC_W-1:0]  result,
    output logic              busy
);

    state_t             state;
    state_t             state_next;
    logic [CNT_W-1:0]   cnt;
    logic [OP_W-1:0]    a_q;
    logic [OP_W-1:0]    b_q;
    logic [ACC_W-1:0]   acc;

    logic [IDX_W-1:0]   idx_a;
    logic [IDX_W-1:0]   idx_b;
    logic [CHUNK-1:0]   slice_a;
    logic [CHUNK-1:0]   slice_b;
    logic [2*CHUNK-1:0] prod;
    logic [ACC_W-1:0]   partial;
    logic               last_step;

    // Upper cnt bits walk the a_q slices, lower bits walk the b_q slices.
    assign idx_a     = cnt[CNT_W-1:IDX_W];
    assign idx_b     = cnt[IDX_W-1:0];
    assign slice_a   = a_q[CHUNK*idx_a +: CHUNK];
    assign slice_b   = b_q[CHUNK*idx_b +: CHUNK];
    assign last_step = (cnt == CNT_W'(SEQ_LAST));

    vedic_multiplier_8x8 u_mul (
        .a (slice_a),
        .b (slice_b),
        .p (prod)
    );

    // Align the partial product to weight 2^(CHUNK*(i+j)) before accumulation.
    always_comb begin
        logic [IDX_W:0] sum_ij;
        int             sh;
        sum_ij  = {1'b0, idx_a} + {1'b0, idx_b};
        sh      = int'(sum_ij) * CHUNK;
        partial = {{(ACC_W-2*CHUNK){1'b0}}, prod} << sh;
    end

    // State register.
    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_next;
    end

    // Next-state logic: accept in IDLE, fixed-length MUL run, hold in DONE until taken.
    // NOTE: state_next gets a default before the case so no path can infer a latch.
    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (in_valid)  state_next = MUL;
            MUL:     if (last_step) state_next = DONE;
            DONE:    if (out_ready) state_next = IDLE;
            default:                state_next = IDLE;
        endcase
    end

    // Operand capture, step counter and accumulator.
    // NOTE: every datapath register is reset so an abandoned run leaves no stale product visible.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a_q <= '0;
            b_q <= '0;
            acc <= '0;
            cnt <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        a_q <= a;
                        b_q <= b;
                        acc <= '0;
                        cnt <= '0;
                    end
                end
                MUL: begin
                    acc <= acc + partial;
                    cnt <= cnt + 1'b1;
                end
                default: ;
            endcase
        end
    end

    assign in_ready  = (state == IDLE);
    assign out_valid = (state == DONE);
    assign busy      = (state != IDLE);
    assign result    = acc;

endmodule
